// File: rtl/spm_driver_if.sv
// Host and spm-side signals of the spm_driver, bundled into one interface.
// Latency: none; wires only.
// Backpressure: valid/ready on the operand and product sides; spm side is free-running.
interface spm_driver_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     mc;
    logic [WIDTH-1:0]     mp;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     spm_x;
    logic                 spm_y;
    logic                 spm_clr;
    logic                 spm_p;

    // Driver side
    modport slave (
        input  in_valid, mc, mp, out_ready, spm_p,
        output in_ready, out_valid, product, spm_x, spm_y, spm_clr
    );

    // Host / spm side
    modport master (
        output in_valid, mc, mp, out_ready, spm_p,
        input  in_ready, out_valid, product, spm_x, spm_y, spm_clr
    );
endinterface

// File: rtl/spm_driver.sv
// Host controller for a serial-parallel multiplier: serialises mp, deserialises mc*mp.
// Latency: accept in cycle A -> out_valid in A+2*WIDTH+3 (A+1 for zero operands with SPM_DRV_ZERO_SKIP_EN).
// Backpressure: in_ready only in IDLE; out_valid/product held until out_ready. Optional macro: SPM_DRV_ZERO_SKIP_EN.
module spm_driver #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    spm_driver_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PW);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]   mp_sh, mp_sh_nxt;
    logic [WIDTH-1:0]   x_q, x_nxt;
    logic               y_q, y_nxt;
    logic [PW-1:0]      prod_q, prod_nxt;
    logic               in_ready_q, in_ready_nxt;
    logic               out_valid_q, out_valid_nxt;
    logic               clr_q, clr_nxt;
    logic               accept;

    assign accept        = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = prod_q;
    assign bus.spm_x     = x_q;
    assign bus.spm_y     = y_q;
    assign bus.spm_clr   = clr_q;

    // Next state and next register values; handshake/clear outputs follow the next state
    // so every output comes straight from a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mp_sh_nxt = mp_sh;
        x_nxt     = x_q;
        y_nxt     = y_q;
        prod_nxt  = prod_q;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SPM_DRV_ZERO_SKIP_EN
                    if (bus.mc == '0 || bus.mp == '0) begin
                        prod_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        x_nxt     = bus.mc;
                        mp_sh_nxt = bus.mp;
                        y_nxt     = 1'b0;
                        state_nxt = CLEAR;
                    end
`else
                    x_nxt     = bus.mc;
                    mp_sh_nxt = bus.mp;
                    y_nxt     = 1'b0;
                    state_nxt = CLEAR;
`endif
                end
            end
            CLEAR: begin
                // First multiplier bit goes out in SHIFT cnt=0
                y_nxt     = mp_sh[0];
                mp_sh_nxt = mp_sh >> 1;
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                // Shift register drains to zero after WIDTH bits: zero extension for free
                y_nxt     = mp_sh[0];
                mp_sh_nxt = mp_sh >> 1;
                // cnt=0 sample is the cleared spm output, not a product bit
                if (cnt != '0)
                    prod_nxt = {bus.spm_p, prod_q[PW-1:1]};
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        clr_nxt       = (state_nxt == CLEAR);
    end

    // State and output registers; reset aborts any operation and holds spm cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mp_sh       <= '0;
            x_q         <= '0;
            y_q         <= 1'b0;
            prod_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            clr_q       <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mp_sh       <= mp_sh_nxt;
            x_q         <= x_nxt;
            y_q         <= y_nxt;
            prod_q      <= prod_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            clr_q       <= clr_nxt;
        end
    end
endmodule

// File: tb/tb_spm_driver.sv
// Directed bench for spm_driver with a behavioural spm attached to its serial side.
// Latency: checked against 2*WIDTH+3 cycles (or 1 with zero skip).
// Backpressure: exercises held out_ready and in_valid while busy.
module tb_spm_driver;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    spm_driver_if #(.WIDTH(W)) bus ();

    spm_driver #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural spm: accumulate x when y is set, emit the LSB, shift right.
    logic [2*W-1:0] spm_acc = '0;
    logic [2*W-1:0] spm_sum;
    assign spm_sum = spm_acc + (bus.spm_y ? {{W{1'b0}}, bus.spm_x} : {2*W{1'b0}});
    always @(posedge clk) begin
        if (bus.spm_clr) begin
            spm_acc   <= '0;
            bus.spm_p <= 1'b0;
        end else begin
            spm_acc   <= spm_sum >> 1;
            bus.spm_p <= spm_sum[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair and return at the falling edge of cycle A+1.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready_timeout", 32'(k < 40), 32'd1);
        bus.in_valid = 1'b1;
        bus.mc       = a;
        bus.mp       = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called in cycle A+1; waits for the product, checks latency and value, holds, then pops it.
    task automatic wait_done(input string tag, input logic [15:0] exp_prod, input int exp_lat,
                             input int hold, input bit junk);
        int k = 1;
        while (bus.out_valid !== 1'b1 && k < 60) begin
            if (junk) begin
                bus.in_valid = 1'b1;
                bus.mc       = W'($urandom);
                bus.mp       = W'($urandom);
            end
            @(negedge clk);
            k++;
        end
        bus.in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
        chk({tag, "_product"}, 32'(bus.product), 32'(exp_prod));
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_product"}, 32'(bus.product), 32'(exp_prod));
            chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_cleared"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_again"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Directed sequence
    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mc        = '0;
        bus.mp        = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_spm_clr",   32'(bus.spm_clr),   32'd1);
        chk("rst_spm_x",     32'(bus.spm_x),     32'd0);
        chk("rst_spm_y",     32'(bus.spm_y),     32'd0);
        chk("rst_product",   32'(bus.product),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_spm_clr",  32'(bus.spm_clr),  32'd0);

        // 13 * 11 = 143 with full latency; CLEAR cycle visible in A+1
        accept(8'd13, 8'd11);
        chk("t1_clear_clr",      32'(bus.spm_clr),  32'd1);
        chk("t1_clear_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t1_clear_y",        32'(bus.spm_y),    32'd0);
        chk("t1_spm_x",          32'(bus.spm_x),    32'd13);
        wait_done("t1", 16'h008F, 19, 0, 1'b0);

        // Largest operands, then 1*1 to expose carry residue
        accept(8'd255, 8'd255);
        wait_done("t2a", 16'hFE01, 19, 0, 1'b0);
        accept(8'd1, 8'd1);
        wait_done("t2b", 16'h0001, 19, 0, 1'b0);

        // Output held for 5 cycles: 200 * 100 = 20000
        accept(8'd200, 8'd100);
        wait_done("t3", 16'h4E20, 19, 5, 1'b0);

        // in_valid with changing operands while busy: 156 * 55 = 8580
        accept(8'd156, 8'd55);
        wait_done("t4", 16'h2184, 19, 0, 1'b1);

        // Reset during SHIFT cnt=7 (cycle A+9), then 6 * 7
        accept(8'hAB, 8'hCD);
        repeat (7) @(negedge clk);
        chk("t5_busy_spm_x", 32'(bus.spm_x), 32'hAB);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_spm_clr",   32'(bus.spm_clr),   32'd1);
        chk("t5_rst_spm_x",     32'(bus.spm_x),     32'd0);
        chk("t5_rst_spm_y",     32'(bus.spm_y),     32'd0);
        chk("t5_rst_product",   32'(bus.product),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_post_spm_clr",  32'(bus.spm_clr),  32'd0);
        accept(8'd6, 8'd7);
        wait_done("t5", 16'h002A, 19, 0, 1'b0);

        // Zero multiplicand
        accept(8'd0, 8'd200);
`ifdef SPM_DRV_ZERO_SKIP_EN
        wait_done("t6", 16'h0000, 1, 0, 1'b0);
`else
        wait_done("t6", 16'h0000, 19, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
